echo_indication_serializer: RTL and testbench
=============================================

ECHO_INDICATION_SERIALIZER -- requirements
Module: echo_indication_serializer

Interface
REQ-001 SHALL have parameter DEPTH, default 2, message FIFO entries (power of two, >= 2).
REQ-002 SHALL have port CLK  input  1  clock, all state on rising edge.
REQ-003 SHALL have port nRST  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port enq__ENA  input  1  upstream message enqueue strobe, asserted only while enq__RDY is high.
REQ-005 SHALL have port enq_v  input  96  packed indication: [31:0] tag, [63:32] meth, [95:64] value.
REQ-006 SHALL have port enq__RDY  output  1  FIFO not full.
REQ-007 SHALL have port word__ENA  output  1  output word transfer, asserted only while word__RDY is high.
REQ-008 SHALL have port word_v  output  32  current output word.
REQ-009 SHALL have port word__RDY  input  1  downstream can accept a word this cycle.

Function
REQ-010 SHALL store each accepted enq_v in a DEPTH-entry FIFO; write on a cycle with enq__ENA high.
REQ-011 SHALL drive enq__RDY = 1 exactly when FIFO occupancy < DEPTH; no same-cycle bypass when full.
REQ-012 SHALL serialize the FIFO head as 3 words in order: header {tag[15:0], 16'd3}, meth, value.
REQ-013 SHALL use FSM states HDR -> METH -> VAL -> HDR, advancing only on a cycle with word__ENA high.
REQ-014 SHALL drive word__ENA = (FIFO not empty) && word__RDY; word_v selected by state from FIFO head.
REQ-015 SHALL pop the FIFO head on the cycle the VAL word transfers.
REQ-016 SHALL keep state and word_v stable while word__RDY is low (stall holds current word).
REQ-017 SHALL allow enqueue and VAL-pop in the same cycle; occupancy unchanged; when full, the pop frees space visible next cycle.
REQ-018 SHALL have minimum latency of one cycle: message written at edge N gives header word_v from cycle N+1.
REQ-019 SHALL sustain one word per cycle with word__RDY held high (3 cycles per message, back-to-back messages without gap).
REQ-020 SHALL wrap FIFO read/write pointers modulo DEPTH; occupancy counter width clog2(DEPTH)+1.
REQ-021 SHALL drive word_v = 0 when FIFO empty.

Reset
REQ-022 SHALL, while nRST low at a clock edge, empty the FIFO, set state HDR, clear counters.
REQ-023 SHALL drive enq__RDY = 0 and word__ENA = 0 while nRST is low.
REQ-024 SHALL discard a partially serialized message when reset asserts mid-message; no residual words after reset.

Configuration
REQ-025 SHALL, with ECHO_SER_COUNTERS_EN defined, add output msg_count[15:0] (messages fully emitted, +1 on each VAL transfer, wraps 0xFFFF->0) and output stall_count[15:0] (cycles FIFO non-empty with word__RDY low, saturating at 0xFFFF).
REQ-026 SHALL, without ECHO_SER_COUNTERS_EN, omit both ports and their registers; all other behaviour identical.

Structure
REQ-027 SHALL place in a shared package: field offsets (TAG, METH, VALUE), header length constant 3, FSM state enum.
REQ-028 SHALL implement the FIFO as one sub-module echo_msg_fifo (parameter DEPTH, WIDTH=96; enq/deq/full/empty).

Verification
REQ-029 SHALL test single message: enq_v {value=0x0000BEEF, meth=0x00000000, tag=1}, word__RDY=1 -> words 0x00010003, 0x00000000, 0x0000BEEF on 3 consecutive cycles starting 1 cycle after enqueue.
REQ-030 SHALL test backpressure: word__RDY low for 5 cycles during METH -> word_v holds meth, no word__ENA, resumes with VAL on first RDY cycle.
REQ-031 SHALL test full: DEPTH=2, word__RDY=0, 2 enqueues -> enq__RDY=0; raise word__RDY -> enq__RDY returns 1 the cycle after first VAL transfer.
REQ-032 SHALL test throughput: 4 back-to-back messages, word__RDY=1 -> 12 consecutive word__ENA cycles, order preserved.
REQ-033 SHALL test reset mid-message: nRST low after header transfer -> FIFO empty, word__ENA=0; next message starts with header.
REQ-034 SHALL test counters (ECHO_SER_COUNTERS_EN): 3 messages, 4 stall cycles -> msg_count=3, stall_count=4.

Source files
------------

// File: rtl/echo_indication_serializer_pkg.sv
// Shared definitions for the echo indication serializer.
// Contents: packed-message field offsets, header length constant,
// word/message widths and the serializer FSM state enum.
package echo_indication_serializer_pkg;

    localparam int WORD_W    = 32;
    localparam int MSG_W     = 96;

    // Bit offsets of each field inside the packed 96-bit indication
    localparam int TAG_LSB   = 0;
    localparam int METH_LSB  = 32;
    localparam int VALUE_LSB = 64;

    // Number of words emitted per message; also the low half of the header
    localparam logic [15:0] HDR_LEN = 16'd3;

    typedef enum logic [1:0] {
        ST_HDR  = 2'd0,
        ST_METH = 2'd1,
        ST_VAL  = 2'd2
    } ser_state_t;

endpackage

// File: rtl/echo_indication_serializer_if.sv
// Handshake bundle for the echo indication serializer.
//   enq__ENA / enq_v / enq__RDY    : upstream message enqueue
//   word__ENA / word_v / word__RDY : downstream 32-bit word stream
// slave modport is the serializer side, master is the environment side.
interface echo_indication_serializer_if;
    import echo_indication_serializer_pkg::*;

    logic              enq__ENA;
    logic [MSG_W-1:0]  enq_v;
    logic              enq__RDY;
    logic              word__ENA;
    logic [WORD_W-1:0] word_v;
    logic              word__RDY;

    modport slave (
        input  enq__ENA, enq_v, word__RDY,
        output enq__RDY, word__ENA, word_v
    );

    modport master (
        output enq__ENA, enq_v, word__RDY,
        input  enq__RDY, word__ENA, word_v
    );

endinterface

// File: rtl/echo_msg_fifo.sv
// Message FIFO for the echo indication serializer.
// Ports:
//   CLK, nRST          : clock, synchronous active-low reset
//   enq, enq_data      : write strobe and data (ignored while full)
//   deq                : pop head (ignored while empty)
//   deq_data           : current head entry
//   full, empty        : occupancy flags
// DEPTH must be a power of two so the pointers wrap naturally.
module echo_msg_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 96
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             enq,
    input  logic [WIDTH-1:0] enq_data,
    input  logic             deq,
    output logic [WIDTH-1:0] deq_data,
    output logic             full,
    output logic             empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_enq;
    logic             do_deq;

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign do_enq   = enq && !full;
    assign do_deq   = deq && !empty;
    assign deq_data = mem[rd_ptr];

    always_ff @(posedge CLK) begin
        if (do_enq) begin
            mem[wr_ptr] <= enq_data;
        end
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_enq) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_deq) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_enq, do_deq})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/echo_indication_serializer.sv
// Echo indication serializer: buffers 96-bit indications and emits each
// as three 32-bit words: header {tag[15:0], 16'd3}, meth, value.
// Ports:
//   CLK, nRST : clock, synchronous active-low reset
//   bus       : echo_indication_serializer_if.slave (enq and word handshakes)
//   msg_count, stall_count : only with ECHO_SER_COUNTERS_EN defined
//     msg_count   - messages fully emitted, wraps
//     stall_count - cycles with data pending and word__RDY low, saturates
//
// state   | meaning
// ST_HDR  | head message header word on word_v
// ST_METH | head message meth word on word_v
// ST_VAL  | head message value word on word_v, pops head on transfer
module echo_indication_serializer
    import echo_indication_serializer_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic CLK,
    input  logic nRST,
    echo_indication_serializer_if.slave bus
`ifdef ECHO_SER_COUNTERS_EN
    ,
    output logic [15:0] msg_count,
    output logic [15:0] stall_count
`endif
);
    ser_state_t        state_q;
    ser_state_t        state_d;
    logic [MSG_W-1:0]  head;
    logic              fifo_full;
    logic              fifo_empty;
    logic              word_ena;
    logic              pop;
    logic [WORD_W-1:0] word_mux;
    logic              unused_tag_hi;

    echo_msg_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (MSG_W)
    ) u_fifo (
        .CLK      (CLK),
        .nRST     (nRST),
        .enq      (bus.enq__ENA),
        .enq_data (bus.enq_v),
        .deq      (pop),
        .deq_data (head),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    // Only the low half of the tag goes into the header
    assign unused_tag_hi = ^head[TAG_LSB+16 +: 16];

    // Gated by nRST so both strobes are low throughout reset
    assign bus.enq__RDY  = nRST && !fifo_full;
    assign word_ena      = nRST && !fifo_empty && bus.word__RDY;
    assign bus.word__ENA = word_ena;
    assign bus.word_v    = fifo_empty ? '0 : word_mux;

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q <= ST_HDR;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        word_mux = '0;
        pop      = 1'b0;
        case (state_q)
            ST_HDR: begin
                word_mux = {head[TAG_LSB +: 16], HDR_LEN};
                if (word_ena) state_d = ST_METH;
            end
            ST_METH: begin
                word_mux = head[METH_LSB +: WORD_W];
                if (word_ena) state_d = ST_VAL;
            end
            ST_VAL: begin
                word_mux = head[VALUE_LSB +: WORD_W];
                if (word_ena) begin
                    state_d = ST_HDR;
                    pop     = 1'b1;
                end
            end
            default: state_d = ST_HDR;
        endcase
    end

`ifdef ECHO_SER_COUNTERS_EN
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            msg_count   <= '0;
            stall_count <= '0;
        end else begin
            if (pop) begin
                msg_count <= msg_count + 16'd1;
            end
            if (!fifo_empty && !bus.word__RDY && (stall_count != 16'hFFFF)) begin
                stall_count <= stall_count + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_echo_indication_serializer.sv
// Directed bench for echo_indication_serializer (DEPTH=2).
// Counter checks are compiled in when ECHO_SER_COUNTERS_EN is defined.
module tb_echo_indication_serializer;

    logic CLK;
    logic nRST;
    int   checks;
    int   errors;

    echo_indication_serializer_if bus ();

`ifdef ECHO_SER_COUNTERS_EN
    logic [15:0] msg_count;
    logic [15:0] stall_count;
`endif

    echo_indication_serializer #(.DEPTH(2)) dut (
        .CLK         (CLK),
        .nRST        (nRST),
        .bus         (bus)
`ifdef ECHO_SER_COUNTERS_EN
        ,
        .msg_count   (msg_count),
        .stall_count (stall_count)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic        enq;
        logic [95:0] v;
        logic        rdy;
        logic        exp_enq_rdy;
        logic        exp_ena;
        logic [31:0] exp_word;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [95:0] msg(input logic [31:0] tag, input logic [31:0] meth,
                                        input logic [31:0] value);
        return {value, meth, tag};
    endfunction

    task automatic add(input logic enq, input logic [95:0] v, input logic rdy,
                       input logic er, input logic ee, input logic [31:0] ew);
        vec_t t;
        t.enq = enq; t.v = v; t.rdy = rdy;
        t.exp_enq_rdy = er; t.exp_ena = ee; t.exp_word = ew;
        vecs.push_back(t);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic drive(input logic enq, input logic [95:0] v, input logic rdy);
        bus.enq__ENA  = enq;
        bus.enq_v     = v;
        bus.word__RDY = rdy;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        nRST = 1'b0;
        drive(1'b0, '0, 1'b1);
        @(negedge CLK);
        check("rst_enq_rdy", 32'(bus.enq__RDY), 32'd0);
        check("rst_word_ena", 32'(bus.word__ENA), 32'd0);
        tick();
        tick();
        nRST = 1'b1;
    endtask

    logic [95:0] tmsg [4];
    logic [31:0] exp_w [12];
    int          nxt;

    initial begin
        checks = 0;
        errors = 0;
        do_reset();

        // single message
        add(1, msg(32'd1, 32'h0, 32'h0000BEEF), 1, 1, 0, 32'h0);
        add(0, '0, 1, 1, 1, 32'h00010003);
        add(0, '0, 1, 1, 1, 32'h00000000);
        add(0, '0, 1, 1, 1, 32'h0000BEEF);
        add(0, '0, 1, 1, 0, 32'h0);
        // backpressure during METH
        add(1, msg(32'd2, 32'h11112222, 32'h33334444), 1, 1, 0, 32'h0);
        add(0, '0, 1, 1, 1, 32'h00020003);
        for (int i = 0; i < 5; i++) add(0, '0, 0, 1, 0, 32'h11112222);
        add(0, '0, 1, 1, 1, 32'h11112222);
        add(0, '0, 1, 1, 1, 32'h33334444);
        add(0, '0, 1, 1, 0, 32'h0);
        // full FIFO, released by first VAL transfer
        add(1, msg(32'd3, 32'hA1, 32'hA2), 0, 1, 0, 32'h0);
        add(1, msg(32'd4, 32'hB1, 32'hB2), 0, 1, 0, 32'h00030003);
        add(0, '0, 0, 0, 0, 32'h00030003);
        add(0, '0, 1, 0, 1, 32'h00030003);
        add(0, '0, 1, 0, 1, 32'h000000A1);
        add(0, '0, 1, 0, 1, 32'h000000A2);
        add(0, '0, 1, 1, 1, 32'h00040003);
        add(0, '0, 1, 1, 1, 32'h000000B1);
        add(0, '0, 1, 1, 1, 32'h000000B2);
        add(0, '0, 1, 1, 0, 32'h0);

        foreach (vecs[i]) begin
            drive(vecs[i].enq, vecs[i].v, vecs[i].rdy);
            @(negedge CLK);
            check($sformatf("vec%0d_enq_rdy", i), 32'(bus.enq__RDY), 32'(vecs[i].exp_enq_rdy));
            check($sformatf("vec%0d_word_ena", i), 32'(bus.word__ENA), 32'(vecs[i].exp_ena));
            check($sformatf("vec%0d_word_v", i), bus.word_v, vecs[i].exp_word);
            tick();
        end

        // throughput: 4 messages, enqueue whenever there is room
        for (int m = 0; m < 4; m++) begin
            tmsg[m] = msg(32'h10 + 32'(m), 32'h100 + 32'(m), 32'h200 + 32'(m));
            exp_w[3*m]     = 32'h00100003 + (32'(m) << 16);
            exp_w[3*m + 1] = 32'h100 + 32'(m);
            exp_w[3*m + 2] = 32'h200 + 32'(m);
        end
        nxt = 0;
        for (int c = 0; c < 14; c++) begin
            if (nxt < 4 && bus.enq__RDY) begin
                drive(1'b1, tmsg[nxt], 1'b1);
                nxt++;
            end else begin
                drive(1'b0, '0, 1'b1);
            end
            @(negedge CLK);
            if (c >= 1 && c <= 12) begin
                check($sformatf("tp%0d_word_ena", c), 32'(bus.word__ENA), 32'd1);
                check($sformatf("tp%0d_word_v", c), bus.word_v, exp_w[c-1]);
            end else begin
                check($sformatf("tp%0d_word_ena", c), 32'(bus.word__ENA), 32'd0);
            end
            tick();
        end

        // reset after header transfer
        drive(1'b1, msg(32'd5, 32'h55, 32'h56), 1'b1);
        tick();
        drive(1'b0, '0, 1'b1);
        @(negedge CLK);
        check("mid_hdr", bus.word_v, 32'h00050003);
        tick();
        nRST = 1'b0;
        @(negedge CLK);
        check("mid_rst_word_ena", 32'(bus.word__ENA), 32'd0);
        check("mid_rst_enq_rdy", 32'(bus.enq__RDY), 32'd0);
        tick();
        nRST = 1'b1;
        @(negedge CLK);
        check("post_rst_word_ena", 32'(bus.word__ENA), 32'd0);
        check("post_rst_word_v", bus.word_v, 32'h0);
        check("post_rst_enq_rdy", 32'(bus.enq__RDY), 32'd1);
        tick();
        drive(1'b1, msg(32'd6, 32'h66, 32'h67), 1'b1);
        tick();
        drive(1'b0, '0, 1'b1);
        @(negedge CLK);
        check("post_rst_hdr_ena", 32'(bus.word__ENA), 32'd1);
        check("post_rst_hdr", bus.word_v, 32'h00060003);
        tick();
        @(negedge CLK);
        check("post_rst_meth", bus.word_v, 32'h66);
        tick();
        @(negedge CLK);
        check("post_rst_val", bus.word_v, 32'h67);
        tick();
        @(negedge CLK);
        check("post_rst_idle", 32'(bus.word__ENA), 32'd0);

`ifdef ECHO_SER_COUNTERS_EN
        tick();
        do_reset();
        @(negedge CLK);
        check("cnt_rst_msg", 32'(msg_count), 32'd0);
        check("cnt_rst_stall", 32'(stall_count), 32'd0);
        tick();
        drive(1'b1, msg(32'd7, 32'h70, 32'h71), 1'b0); tick();
        drive(1'b1, msg(32'd8, 32'h80, 32'h81), 1'b0); tick();
        drive(1'b0, '0, 1'b0); tick();
        for (int i = 0; i < 3; i++) begin drive(1'b0, '0, 1'b1); tick(); end
        drive(1'b1, msg(32'd9, 32'h90, 32'h91), 1'b0); tick();
        drive(1'b0, '0, 1'b0); tick();
        for (int i = 0; i < 6; i++) begin drive(1'b0, '0, 1'b1); tick(); end
        drive(1'b0, '0, 1'b0); tick();
        drive(1'b0, '0, 1'b1); tick();
        @(negedge CLK);
        check("cnt_msg", 32'(msg_count), 32'd3);
        check("cnt_stall", 32'(stall_count), 32'd4);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
